// File: rtl/uart_boot_loader.sv
// uart_boot_loader: autobaud UART loader writing N big-endian words to instruction memory, then releasing the CPU.
// Define BOOT_CHECKSUM_EN to require a trailing checksum word (sum of payload words mod 2^32).
`timescale 1ns/1ps
module uart_boot_loader #(
    parameter int          DIV_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          MIN_DIV   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_reset_n,
    output logic             boot_done,
    output logic             boot_error,
    output logic [DIV_W-1:0] baud_div
);
    // Wide enough to hold the 9-bit-period skip after the sync byte.
    localparam int CW = DIV_W + 4;
    localparam logic [CW-1:0] CNT_SAT = {4'd0, {DIV_W{1'b1}}};
    localparam logic [CW-1:0] MIN_C   = CW'(MIN_DIV);

    typedef enum logic [3:0] {SYNC, MEASURE, SKIP, IDLE, START, DATA, STOP, DONE, ERROR} state_t;

    state_t state_q, state_d;
    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] baud_div_q, baud_div_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_q, byte_d;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d, n_q, n_d, rcv_cnt_q, rcv_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic have_n_q, have_n_d, mem_valid_q, mem_valid_d;
    logic word_done, csum_ok;
    logic [31:0] new_word;
    logic [CW-1:0] div_c, half_c, skip_c;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic csum_ok_q, csum_ok_d;
    assign csum_ok = csum_ok_q;
`else
    assign csum_ok = 1'b1;
`endif

    assign div_c    = {4'd0, baud_div_q};
    assign half_c   = {5'd0, baud_div_q[DIV_W-1:1]};
    assign skip_c   = div_c * CW'(9) - CW'(1);
    assign new_word = {word_q[23:0], byte_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        baud_div_d  = baud_div_q;
        bit_cnt_d   = bit_cnt_q;
        byte_d      = byte_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        n_d         = n_q;
        rcv_cnt_d   = rcv_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        have_n_d    = have_n_q;
        mem_valid_d = mem_valid_q;
        word_done   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_d       = sum_q;
        csum_ok_d   = csum_ok_q;
`endif
        if (mem_valid_q && mem_ready) begin
            mem_valid_d = 1'b0;
            mem_addr_d  = mem_addr_q + 32'd4;
            wr_cnt_d    = wr_cnt_q + 32'd1;
        end
        case (state_q)
            SYNC: if (!rx_s_q) begin
                state_d = MEASURE;
                cnt_d   = CW'(1);
            end
            MEASURE: if (rx_s_q) begin
                if (cnt_q < MIN_C) state_d = SYNC;
                else begin
                    baud_div_d = cnt_q[DIV_W-1:0];
                    cnt_d      = CW'(1);
                    state_d    = SKIP;
                end
            end else if (cnt_q == CNT_SAT) state_d = ERROR;
            else cnt_d = cnt_q + CW'(1);
            SKIP: if (cnt_q >= skip_c) state_d = IDLE;
            else cnt_d = cnt_q + CW'(1);
            IDLE: if (rx_prev_q && !rx_s_q) begin
                state_d = START;
                cnt_d   = CW'(1);
            end
            START: if (cnt_q >= half_c) begin
                state_d   = rx_s_q ? IDLE : DATA;
                cnt_d     = CW'(1);
                bit_cnt_d = 3'd0;
            end else cnt_d = cnt_q + CW'(1);
            DATA: if (cnt_q >= div_c) begin
                byte_d    = {rx_s_q, byte_q[7:1]};
                cnt_d     = CW'(1);
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = STOP;
            end else cnt_d = cnt_q + CW'(1);
            STOP: if (cnt_q >= div_c) begin
                if (!rx_s_q) state_d = ERROR;
                else begin
                    state_d    = IDLE;
                    word_d     = new_word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    word_done  = byte_cnt_q == 2'd3;
                end
            end else cnt_d = cnt_q + CW'(1);
            default: ;
        endcase
        if (word_done) begin
            if (!have_n_q) begin
                have_n_d = 1'b1;
                n_d      = new_word;
                if (new_word > 32'(MAX_WORDS)) state_d = ERROR;
            end else if (rcv_cnt_q != n_q) begin
                // A handshake on this same cycle frees the port, so only a stalled write is an overrun.
                if (mem_valid_q && !mem_ready) state_d = ERROR;
                else begin
                    mem_valid_d = 1'b1;
                    mem_wdata_d = new_word;
                    rcv_cnt_d   = rcv_cnt_q + 32'd1;
`ifdef BOOT_CHECKSUM_EN
                    sum_d       = sum_q + new_word;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            else if (!csum_ok_q) begin
                if (new_word == sum_q) csum_ok_d = 1'b1;
                else state_d = ERROR;
            end
`endif
        end
        if (have_n_q && wr_cnt_q == n_q && !mem_valid_q && csum_ok && state_d != ERROR) state_d = DONE;
        if (state_d == ERROR) mem_valid_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= SYNC;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            cnt_q       <= '0;
            baud_div_q  <= '0;
            bit_cnt_q   <= '0;
            byte_q      <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            n_q         <= '0;
            rcv_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            have_n_q    <= 1'b0;
            mem_valid_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q       <= '0;
            csum_ok_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            cnt_q       <= cnt_d;
            baud_div_q  <= baud_div_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_q      <= byte_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            n_q         <= n_d;
            rcv_cnt_q   <= rcv_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            have_n_q    <= have_n_d;
            mem_valid_q <= mem_valid_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q       <= sum_d;
            csum_ok_q   <= csum_ok_d;
`endif
        end
    end

    assign mem_valid   = mem_valid_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign baud_div    = baud_div_q;
    assign boot_done   = state_q == DONE;
    assign cpu_reset_n = state_q == DONE;
    assign boot_error  = state_q == ERROR;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed UART loads with a write scoreboard checked by a negedge monitor.
`timescale 1ns/1ps
module tb_uart_boot_loader;
    localparam int BIT = 20;
    localparam int GAP = 20;
    localparam int COMPLETE_CYC = 192;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clock = 1'b0, reset = 1'b0, rx = 1'b1, mem_ready = 1'b1;
    logic mem_valid, cpu_reset_n, boot_done, boot_error;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] baud_div;
    int checks = 0, failures = 0;
    wr_t exp_q[$];
    wr_t mon_e;
    logic [31:0] prog [8] = '{32'h00000013, 32'h20000137, 32'h02010113, 32'h00800193,
                              32'h00012223, 32'h00012023, 32'h00312023, 32'hFF9FF06F};
    logic [31:0] prog_sum;

    uart_boot_loader dut (
        .clock(clock), .reset(reset), .rx(rx), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset_n(cpu_reset_n),
        .boot_done(boot_done), .boot_error(boot_error), .baud_div(baud_div)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && mem_valid && mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h/%h required=none", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", mem_addr, mon_e.a);
                check("wr_data", mem_wdata, mon_e.d);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_vals();
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_reset_n", cpu_reset_n, 0);
        check("rst_boot_done", boot_done, 0);
        check("rst_boot_error", boot_error, 0);
        check("rst_baud_div", baud_div, 0);
    endtask

    task automatic do_reset();
        rx = 1'b1;
        mem_ready = 1'b1;
        reset = 1'b0;
        tick(3);
        exp_q.delete();
        reset = 1'b1;
        tick(1);
    endtask

    // rdy_at: cycle within the frame (0 = start bit) at which mem_ready is raised; -1 leaves it alone.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int rdy_at);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int c = 0; c < 10 * BIT + GAP; c++) begin
            if (c == rdy_at) mem_ready = 1'b1;
            rx = (c < 10 * BIT) ? fr[c / BIT] : 1'b1;
            tick(1);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int rdy_at);
        send_byte(w[31:24], 1'b1, -1);
        send_byte(w[23:16], 1'b1, -1);
        send_byte(w[15:8], 1'b1, -1);
        send_byte(w[7:0], 1'b1, rdy_at);
    endtask

    task automatic load_payload();
        send_byte(8'hFF, 1'b1, -1);
        send_word(32'd8, -1);
        for (int i = 0; i < 8; i++) begin
            push(32'(4 * i), prog[i]);
            send_word(prog[i], -1);
        end
    endtask

    task automatic finish_check(input string name, input logic d, input logic e);
        for (int i = 0; i < 2000 && !(boot_done || boot_error); i++) tick(1);
        tick(5);
        $display("test %s", name);
        check("boot_done", boot_done, d);
        check("boot_error", boot_error, e);
        check("cpu_reset_n", cpu_reset_n, d);
        check("mem_valid_end", mem_valid, 0);
        check("writes_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        prog_sum = '0;
        for (int i = 0; i < 8; i++) prog_sum += prog[i];
        // reset values and autobaud with a leading glitch shorter than MIN_DIV
        reset = 1'b0;
        tick(3);
        check_reset_vals();
        reset = 1'b1;
        tick(1);
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(30);
        send_byte(8'hFF, 1'b1, -1);
        check("baud_div", baud_div, 20);
        check("autobaud_mem_valid", mem_valid, 0);
        check("autobaud_done", boot_done, 0);
        check("autobaud_error", boot_error, 0);
        check("autobaud_cpu_reset_n", cpu_reset_n, 0);

        do_reset();
        load_payload();
`ifdef BOOT_CHECKSUM_EN
        send_word(prog_sum, -1);
`endif
        finish_check("nominal", 1'b1, 1'b0);

        do_reset();
        send_byte(8'hFF, 1'b1, -1);
        send_word(32'd0, -1);
`ifdef BOOT_CHECKSUM_EN
        send_word(32'd0, -1);
`endif
        finish_check("empty", 1'b1, 1'b0);

        do_reset();
        send_byte(8'hFF, 1'b1, -1);
        send_word(32'd1025, -1);
        finish_check("limit", 1'b0, 1'b1);

        do_reset();
        send_byte(8'hFF, 1'b1, -1);
        send_word(32'd1, -1);
        send_byte(8'h11, 1'b1, -1);
        send_byte(8'h22, 1'b0, -1);
        send_byte(8'h33, 1'b1, -1);
        send_byte(8'h44, 1'b1, -1);
        finish_check("framing", 1'b0, 1'b1);

        do_reset();
        mem_ready = 1'b0;
        send_byte(8'hFF, 1'b1, -1);
        send_word(32'd2, -1);
        send_word(32'hA5A5_0001, -1);
        check("overrun_pending", mem_valid, 1);
        send_word(32'hA5A5_0002, -1);
        finish_check("overrun", 1'b0, 1'b1);

        do_reset();
        mem_ready = 1'b0;
        send_byte(8'hFF, 1'b1, -1);
        send_word(32'd2, -1);
        push(32'h0, 32'hA5A5_0001);
        push(32'h4, 32'hA5A5_0002);
        send_word(32'hA5A5_0001, -1);
        check("same_cycle_pending", mem_valid, 1);
        send_word(32'hA5A5_0002, COMPLETE_CYC);
`ifdef BOOT_CHECKSUM_EN
        send_word(32'hA5A5_0001 + 32'hA5A5_0002, -1);
`endif
        finish_check("same_cycle", 1'b1, 1'b0);

        do_reset();
        send_byte(8'hFF, 1'b1, -1);
        send_word(32'd8, -1);
        for (int i = 0; i < 3; i++) begin
            push(32'(4 * i), prog[i]);
            send_word(prog[i], -1);
        end
        check("midload_writes", exp_q.size(), 0);
        reset = 1'b0;
        tick(3);
        check_reset_vals();
        reset = 1'b1;
        tick(1);
        load_payload();
`ifdef BOOT_CHECKSUM_EN
        send_word(prog_sum, -1);
`endif
        finish_check("reload", 1'b1, 1'b0);

`ifdef BOOT_CHECKSUM_EN
        do_reset();
        load_payload();
        send_word(prog_sum + 32'd1, -1);
        finish_check("bad_checksum", 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
